// File: rtl/cini_gadget_sched.sv
// Issue scheduler for the 2-share CINI masked AND gadget: b/rand at t, a at t+1,
// result capture at t+2 into a credit-protected output FIFO, with drain/flush.

module cini_gadget_sched_lane (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  input  logic live_a,
  input  logic in_a_0,
  input  logic in_a_1,
  input  logic in_b_0,
  input  logic in_b_1,
  output logic g_a_0,
  output logic g_a_1,
  output logic g_b_0,
  output logic g_b_1
);
  logic a0_q, a1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a0_q <= 1'b0;
      a1_q <= 1'b0;
    end else if (accept) begin
      a0_q <= in_a_0;
      a1_q <= in_a_1;
    end
  end

  // Shares are gated so the gadget never sees stale data on an idle slot.
  assign g_b_0 = accept & in_b_0;
  assign g_b_1 = accept & in_b_1;
  assign g_a_0 = live_a & a0_q;
  assign g_a_1 = live_a & a1_q;
endmodule

module cini_gadget_sched #(
  parameter int WIDTH     = 3,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a_0,
  input  logic [WIDTH-1:0] in_a_1,
  input  logic [WIDTH-1:0] in_b_0,
  input  logic [WIDTH-1:0] in_b_1,
  input  logic             rng_valid,
  output logic             rng_ready,
  input  logic             rng_data,
  output logic [WIDTH-1:0] g_a_0,
  output logic [WIDTH-1:0] g_a_1,
  output logic [WIDTH-1:0] g_b_0,
  output logic [WIDTH-1:0] g_b_1,
  output logic             g_rand,
  input  logic [WIDTH-1:0] g_c_0,
  input  logic [WIDTH-1:0] g_c_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c_0,
  output logic [WIDTH-1:0] out_c_1,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
  localparam int STAGES = 2;
  localparam int AW     = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
  } res_t;

  state_t           state;
  logic             alive;
  logic [STAGES:1]  vld_pipe;
  logic [1:0]       inflight;
  logic [AW:0]      wr_ptr, rd_ptr, fifo_cnt;
  logic [AW+1:0]    used;
  logic             accept, push, pop, full, clear;
  res_t             mem [OUT_DEPTH];
  res_t             push_res, head;

  // alive keeps the handshake closed while reset is held, whatever rng_valid does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign inflight = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]};
  assign fifo_cnt = wr_ptr - rd_ptr;
  assign used     = {1'b0, fifo_cnt} + {{AW{1'b0}}, inflight};
  assign full     = (fifo_cnt == (AW+1)'(OUT_DEPTH));

  // Credit counts slots already promised to in-flight ops, so a push never overflows.
  assign in_ready  = alive & (state != DRAIN) & ~flush & rng_valid
                   & (used < (AW+2)'(OUT_DEPTH));
  assign accept    = in_valid & in_ready;
  assign rng_ready = accept;
  assign g_rand    = accept & rng_data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    cini_gadget_sched_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .accept (accept),
      .live_a (vld_pipe[1]),
      .in_a_0 (in_a_0[i]),
      .in_a_1 (in_a_1[i]),
      .in_b_0 (in_b_0[i]),
      .in_b_1 (in_b_1[i]),
      .g_a_0  (g_a_0[i]),
      .g_a_1  (g_a_1[i]),
      .g_b_0  (g_b_0[i]),
      .g_b_1  (g_b_1[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], accept};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!flush && in_valid) state <= RUN;
        RUN:     if (flush) state <= DRAIN;
                 else if (!accept && inflight == 2'd0) state <= IDLE;
        DRAIN:   if (inflight == 2'd0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign clear    = ((state == DRAIN) && (inflight == 2'd0)) || ((state == IDLE) && flush);
  assign push     = vld_pipe[STAGES];
  assign pop      = out_valid & out_ready;
  assign push_res = {g_c_0, g_c_1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_res;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    op_cnt <= '0;
    else if (push) op_cnt <= op_cnt + CNT_W'(1);
  end

  always @(posedge clk) begin
    if (reset) assert (!(push && full && !pop));
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = (wr_ptr != rd_ptr);
  assign out_c_0   = out_valid ? head.c0 : '0;
  assign out_c_1   = out_valid ? head.c1 : '0;
  assign busy      = (state != IDLE) || (inflight != 2'd0) || out_valid;
endmodule

// File: tb/tb_cini_gadget_sched.sv
// Directed bench for cini_gadget_sched with a behavioural 2-share gadget and a result scoreboard.

module tb_cini_gadget_sched;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, rng_valid, rng_ready, rng_data;
  logic [W-1:0] in_a_0, in_a_1, in_b_0, in_b_1;
  logic [W-1:0] g_a_0, g_a_1, g_b_0, g_b_1, g_c_0, g_c_1;
  logic         g_rand, out_valid, out_ready, flush, busy;
  logic [W-1:0] out_c_0, out_c_1;
  logic [15:0]  op_cnt;

  always #5 clk = ~clk;

  cini_gadget_sched #(.WIDTH(W), .OUT_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_0(in_a_0), .in_a_1(in_a_1), .in_b_0(in_b_0), .in_b_1(in_b_1),
    .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_data(rng_data),
    .g_a_0(g_a_0), .g_a_1(g_a_1), .g_b_0(g_b_0), .g_b_1(g_b_1), .g_rand(g_rand),
    .g_c_0(g_c_0), .g_c_1(g_c_1),
    .out_valid(out_valid), .out_ready(out_ready), .out_c_0(out_c_0), .out_c_1(out_c_1),
    .flush(flush), .busy(busy), .op_cnt(op_cnt)
  );

  // Gadget model: b/rand captured at t, a used at t+1, c presented during t+2.
  logic [W-1:0] gb0_r, gb1_r, gc0_r, gc1_r;
  logic         gr_r;
  always @(posedge clk) begin
    gb0_r <= g_b_0;
    gb1_r <= g_b_1;
    gr_r  <= g_rand;
    gc0_r <= (g_a_0 & gb0_r) ^ (g_a_0 & gb1_r) ^ {W{gr_r}};
    gc1_r <= (g_a_1 & gb1_r) ^ (g_a_1 & gb0_r) ^ {W{gr_r}};
  end
  assign g_c_0 = gc0_r;
  assign g_c_1 = gc1_r;

  typedef struct { logic [W-1:0] c0; logic [W-1:0] c1; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, n_acc = 0, n_pop = 0;
  int base, pbase, cnt;

  function automatic exp_t model(input logic [W-1:0] a0, a1, b0, b1, input logic r);
    exp_t e;
    e.c0 = (a0 & b0) ^ (a0 & b1) ^ {W{r}};
    e.c1 = (a1 & b1) ^ (a1 & b0) ^ {W{r}};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] a0, a1, b0, b1, input logic r);
    in_a_0 = a0; in_a_1 = a1; in_b_0 = b0; in_b_1 = b1; rng_data = r;
    in_valid = 1'b1; rng_valid = 1'b1;
  endtask

  task automatic drive_rand;
    drive(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (busy && k < max) begin cyc; k++; end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_g_a_0"}, 32'(g_a_0), 0);   chk({pfx, "_g_a_1"}, 32'(g_a_1), 0);
    chk({pfx, "_g_b_0"}, 32'(g_b_0), 0);   chk({pfx, "_g_b_1"}, 32'(g_b_1), 0);
    chk({pfx, "_g_rand"}, 32'(g_rand), 0); chk({pfx, "_in_ready"}, 32'(in_ready), 0);
    chk({pfx, "_rng_ready"}, 32'(rng_ready), 0); chk({pfx, "_out_valid"}, 32'(out_valid), 0);
    chk({pfx, "_out_c_0"}, 32'(out_c_0), 0); chk({pfx, "_out_c_1"}, 32'(out_c_1), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);     chk({pfx, "_op_cnt"}, 32'(op_cnt), 0);
  endtask

  // Scoreboard: push on accept, pop and compare exact shares on each FIFO pop.
  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a_0, in_a_1, in_b_0, in_b_1, rng_data));
        n_acc++;
        chk("rng_handshake", 32'(rng_ready), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("pop_without_op", 32'(out_valid), 32'd0);
        else begin
          mon_e = sb.pop_front();
          n_pop++;
          chk("out_c_0", 32'(out_c_0), 32'(mon_e.c0));
          chk("out_c_1", 32'(out_c_1), 32'(mon_e.c1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(3'b111, 3'b101, 3'b110, 3'b011, 1'b1);
    repeat (2) cyc;
    smp; chk_all_zero("rst");
    cyc; in_valid = 1'b0; rng_valid = 1'b0; reset = 1'b1;
    repeat (2) cyc;

    // 1: single op and its cycle-by-cycle gadget drive
    out_ready = 1'b0;
    drive(3'b101, 3'b011, 3'b110, 3'b000, 1'b1);
    smp;
    chk("t1_in_ready", 32'(in_ready), 1); chk("t1_g_b_0", 32'(g_b_0), 32'b110);
    chk("t1_g_b_1", 32'(g_b_1), 0);       chk("t1_g_rand", 32'(g_rand), 1);
    chk("t1_g_a_0_idle", 32'(g_a_0), 0);
    cyc; in_valid = 1'b0; rng_valid = 1'b0; smp;
    chk("t1_g_a_0", 32'(g_a_0), 32'b101); chk("t1_g_a_1", 32'(g_a_1), 32'b011);
    chk("t1_g_b_0_idle", 32'(g_b_0), 0);  chk("t1_g_rand_idle", 32'(g_rand), 0);
    chk("t1_ov_t1", 32'(out_valid), 0);
    cyc; smp; chk("t1_ov_t2", 32'(out_valid), 0);
    cyc; out_ready = 1'b1; smp;
    chk("t1_ov_t3", 32'(out_valid), 1);
    chk("t1_and", 32'(out_c_0 ^ out_c_1), 32'((3'b101 ^ 3'b011) & (3'b110 ^ 3'b000)));
    cyc; smp; chk("t1_ov_after", 32'(out_valid), 0); chk("t1_op_cnt", 32'(op_cnt), 1);

    // 2: ten back-to-back ops at full rate
    base = n_acc; pbase = n_pop;
    for (int i = 0; i < 10; i++) begin
      cyc; drive_rand; smp;
      chk("t2_in_ready", 32'(in_ready), 1);
      if (i >= 3) chk("t2_stream", 32'(out_valid), 1);
    end
    cyc; in_valid = 1'b0; rng_valid = 1'b0;
    wait_idle(20);
    chk("t2_op_cnt", 32'(op_cnt), 32'(base + 10));
    chk("t2_pops", 32'(n_pop - pbase), 32'd10);
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // 3: credit limit with a stalled consumer
    out_ready = 1'b0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc; drive_rand; smp;
      if (in_valid && in_ready) cnt++;
    end
    chk("t3_accepts", 32'(cnt), 4); chk("t3_blocked", 32'(in_ready), 0);
    cnt = 0;
    cyc; out_ready = 1'b1; smp; if (in_valid && in_ready) cnt++;
    cyc; out_ready = 1'b0; smp; if (in_valid && in_ready) cnt++;
    for (int i = 0; i < 8; i++) begin
      cyc; smp; if (in_valid && in_ready) cnt++;
    end
    chk("t3_one_more", 32'(cnt), 1);
    cyc; in_valid = 1'b0; rng_valid = 1'b0; out_ready = 1'b1;
    wait_idle(30);

    // 4: operand waiting on the RNG
    out_ready = 1'b0;
    drive(3'b010, 3'b100, 3'b111, 3'b101, 1'b1);
    rng_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("t4_in_ready", 32'(in_ready), 0);  chk("t4_rng_ready", 32'(rng_ready), 0);
      chk("t4_g_b_0", 32'(g_b_0), 0);        chk("t4_g_b_1", 32'(g_b_1), 0);
      chk("t4_g_a_0", 32'(g_a_0), 0);        chk("t4_g_rand", 32'(g_rand), 0);
      cyc;
    end
    rng_valid = 1'b1; smp;
    chk("t4_accept", 32'(in_ready), 1); chk("t4_rng_ready_go", 32'(rng_ready), 1);
    chk("t4_g_b_0_go", 32'(g_b_0), 32'b111); chk("t4_g_rand_go", 32'(g_rand), 1);
    cyc; in_valid = 1'b0; rng_valid = 1'b0; out_ready = 1'b1;
    wait_idle(20);

    // 5: flush with two ops in flight and one queued
    out_ready = 1'b0; base = n_acc;
    for (int i = 0; i < 3; i++) begin
      cyc; drive_rand; smp; chk("t5_in_ready", 32'(in_ready), 1);
    end
    cyc; flush = 1'b1; smp;
    chk("t5_flush_block", 32'(in_ready), 0); chk("t5_flush_rng", 32'(rng_ready), 0);
    chk("t5_queued", 32'(out_valid), 1);
    cyc; flush = 1'b0; smp; chk("t5_drain_block", 32'(in_ready), 0);
    cyc; in_valid = 1'b0; rng_valid = 1'b0;
    wait_idle(20);
    chk("t5_ov", 32'(out_valid), 0);
    chk("t5_op_cnt", 32'(op_cnt), 32'(base + 3));
    sb.delete();

    // 5b: flush while idle still discards the FIFO
    cyc; drive_rand; smp; chk("t5b_in_ready", 32'(in_ready), 1);
    cyc; in_valid = 1'b0; rng_valid = 1'b0;
    repeat (5) cyc;
    smp; chk("t5b_ov", 32'(out_valid), 1); chk("t5b_busy", 32'(busy), 1);
    cyc; flush = 1'b1; cyc; flush = 1'b0; smp;
    chk("t5b_ov_clear", 32'(out_valid), 0); chk("t5b_busy_clear", 32'(busy), 0);
    sb.delete();

    // 6: reset in the middle of a stream
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin cyc; drive_rand; smp; end
    cyc; reset = 1'b0; #1;
    chk_all_zero("mid_rst");
    sb.delete();
    cyc; cyc; reset = 1'b1; in_valid = 1'b0; rng_valid = 1'b0;
    cyc; cyc;
    drive(3'b110, 3'b001, 3'b011, 3'b100, 1'b0); smp;
    chk("t6_in_ready", 32'(in_ready), 1);
    cyc; in_valid = 1'b0; rng_valid = 1'b0; smp; chk("t6_ov_t1", 32'(out_valid), 0);
    cyc; smp; chk("t6_ov_t2", 32'(out_valid), 0);
    cyc; smp; chk("t6_ov_t3", 32'(out_valid), 1);
    cyc; smp; chk("t6_op_cnt", 32'(op_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
